// File: rtl/slc3_button_conditioner_pkg.sv
// Shared types and debounce-length helper for the SLC-3 button conditioner.
// SLC3_SIM_FAST_DEBOUNCE_EN shortens the debounce window for simulation.
package slc3_btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;

  // Effective debounce window: forced short in fast-sim builds, as given otherwise.
  function automatic int unsigned eff_debounce(input int unsigned cycles);
`ifdef SLC3_SIM_FAST_DEBOUNCE_EN
    return (cycles != 0) ? SIM_DEBOUNCE_CYCLES : SIM_DEBOUNCE_CYCLES;
`else
    return cycles;
`endif
  endfunction

endpackage

// File: rtl/slc3_button_conditioner_debounce.sv
// One push-button channel: synchronizer, saturating debounce counter and
// press/release FSM producing a debounced level and a one-cycle press pulse.
module button_debounce
  import slc3_btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_level,
  output logic o_pulse
);

  localparam int unsigned DEB = eff_debounce(DEBOUNCE_CYCLES);
  localparam int unsigned CW  = (DEB > 1) ? $clog2(DEB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_pressed;

  btn_state_t    r_state;
  btn_state_t    w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          r_level;
  logic          r_pulse;
  logic          w_level_nxt;
  logic          w_pulse_nxt;

  // Synchronizer resets to the released (high) level of the active-low key.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_key_n};
    end
  end

  assign w_pressed = ~r_sync[SYNC_STAGES-1];
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_pressed) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      PRESS_WAIT: begin
        if (!w_pressed) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      HELD: begin
        if (!w_pressed) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = CW'(1);
        end
      end
      RELEASE_WAIT: begin
        if (w_pressed) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level and pulse change only on the accepting transitions.
  always_comb begin
    w_level_nxt = r_level;
    w_pulse_nxt = 1'b0;
    if ((r_state == PRESS_WAIT) && w_pressed && (r_cnt == CNT_LAST)) begin
      w_level_nxt = 1'b1;
      w_pulse_nxt = 1'b1;
    end
    if ((r_state == RELEASE_WAIT) && !w_pressed && (r_cnt == CNT_LAST)) begin
      w_level_nxt = 1'b0;
    end
  end

  assign o_level = r_level;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/slc3_button_conditioner.sv
// Conditions the raw Run/Continue keys into debounced levels and press pulses.
// Define SLC3_SIM_FAST_DEBOUNCE_EN for a 4-cycle debounce window in simulation.
module slc3_button_conditioner
  import slc3_btn_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run_n,
  input  logic Continue_n,
  output logic Run_level,
  output logic Continue_level,
  output logic Run_pulse,
  output logic Continue_pulse
);

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_run (
    .clk     (Clk),
    .rst     (Reset),
    .i_key_n (Run_n),
    .o_level (Run_level),
    .o_pulse (Run_pulse)
  );

  button_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_continue (
    .clk     (Clk),
    .rst     (Reset),
    .i_key_n (Continue_n),
    .o_level (Continue_level),
    .o_pulse (Continue_pulse)
  );

endmodule

// File: doc/slc3_button_conditioner.md
# slc3_button_conditioner

Conditions the raw DE10-Lite push-button inputs (Run, Continue) before they reach the SLC-3 top and its ISDU. Each button gets a synchronizer, a debounce counter and a press/release FSM, producing a clean debounced level plus a single-cycle press pulse. It sits directly upstream of the SLC-3 core; the core consumes only conditioned signals, never raw keys.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count, minimum 2.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz). Minimum 2.
- `Clk` input 1: system clock, 50 MHz.
- `Reset` input 1: asynchronous, active-high reset.
- `Run_n` input 1: raw Run key, active-low, asynchronous to `Clk`.
- `Continue_n` input 1: raw Continue key, active-low, asynchronous to `Clk`.
- `Run_level` output 1: debounced Run, active-high.
- `Continue_level` output 1: debounced Continue, active-high.
- `Run_pulse` output 1: one-cycle strobe on accepted Run press.
- `Continue_pulse` output 1: one-cycle strobe on accepted Continue press.

## Operation
- The two buttons are fully independent identical channels. Nothing is shared except `Clk` and `Reset`.
- Synchronizer: a `SYNC_STAGES`-deep flop chain. Its output is inverted to get `pressed` (active-high).
- Counter: `$clog2(DEBOUNCE_CYCLES)` bits wide, unsigned, saturating. It never wraps.
- FSM states and transitions:
  - IDLE (released): if `pressed`=1, go to PRESS_WAIT with counter=1.
  - PRESS_WAIT:
    - If `pressed`=0, return to IDLE and clear the counter.
    - Otherwise, if counter = `DEBOUNCE_CYCLES`-1, go to HELD. This sets `*_level`=1 and asserts `*_pulse` for exactly that one cycle.
    - Otherwise, increment the counter.
  - HELD: if `pressed`=0, go to RELEASE_WAIT with counter=1.
  - RELEASE_WAIT:
    - If `pressed`=1, return to HELD and clear the counter. No pulse is issued.
    - Otherwise, if counter = `DEBOUNCE_CYCLES`-1, go to IDLE and set `*_level`=0.
    - Otherwise, increment the counter.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- Holding a button produces exactly one pulse, with no auto-repeat.
- Simultaneous presses on both buttons may pulse in the same cycle. Both are reported.

## Timing
- Reset values:
  - sync flops = 1 (released)
  - all counters = 0
  - FSMs = IDLE
  - `Run_level` = `Continue_level` = `Run_pulse` = `Continue_pulse` = 0
- Reset mid-debounce or mid-hold: the channel aborts immediately and asynchronously to IDLE. No pulse is emitted during or on exit from reset.
- Key held across reset deassertion: it is treated as a new press. The pulse follows the full latency below.
- Press latency: a clean raw falling edge sampled at edge k gives `*_level` rising and `*_pulse` high at edge k + `SYNC_STAGES` + `DEBOUNCE_CYCLES` - 1.
- Release latency: identical, measured from the raw rising edge.
- `*_pulse` is exactly 1 cycle wide. It is registered and coincident with the `*_level` rise.

## Configuration
- `SLC3_SIM_FAST_DEBOUNCE_EN`:
  - Defined: the effective debounce length is forced to 4, regardless of `DEBOUNCE_CYCLES`. Simulation benches use this so that button stimulus at tens-of-ns spacing is accepted.
  - Undefined: `DEBOUNCE_CYCLES` is used as given. This is required for synthesis.

## Structure
- Package `slc3_btn_pkg` holds:
  - enum `btn_state_t` {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT}
  - constant `SIM_DEBOUNCE_CYCLES = 4`
  - function `eff_debounce(int)` that applies the macro override
- Sub-module `button_debounce` contains one channel (sync, counter, FSM; outputs level and pulse). It is instantiated twice by `slc3_button_conditioner`.

## Test plan
All scenarios are built with `SLC3_SIM_FAST_DEBOUNCE_EN`, `SYNC_STAGES`=2 and effective debounce 4.
- Reset held 3 cycles, keys released: all outputs 0 throughout. FSMs are in IDLE after release.
- `Run_n` driven low at edge 10 and held: `Run_level`=1 and `Run_pulse`=1 at edge 15 only. `Run_pulse`=0 from edge 16 onward while held.
- `Continue_n` bounce low 2 cycles / high 1 / low 2 / high: no `Continue_level` or `Continue_pulse` activity at any time.
- Both keys driven low at the same edge: both pulses fire at the same edge, 5 cycles later, each for 1 cycle.
- `Run_n` released after HELD, with a 2-cycle re-press glitch during RELEASE_WAIT: `Run_level` stays 1 and no second pulse. A clean release drops `Run_level` 5 cycles after the final rising edge.
- `Reset` asserted during PRESS_WAIT (counter=2): outputs stay 0 immediately and no pulse. Key still low after reset: pulse 5 cycles after deassertion.
